// File: rtl/vliw_pkg.sv
`default_nettype none
// vliw_pkg: shared lane/shadow configuration and arbiter state encoding.
// Rev 1.0
package vliw_pkg;

  localparam int NUM_LANES     = 4;
  localparam int SHADOW_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHADOW = 2'd1,
    HALTED = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/lane_priority_encoder.sv
`default_nettype none
// lane_priority_encoder: any-set flag plus index of the lowest set lane (oldest).
// Rev 1.0
module lane_priority_encoder #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  import vliw_pkg::*;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = |vec;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[IDX_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_arbiter.sv
`default_nettype none
// branch_arbiter: picks the oldest taken branch per bundle, shadows squashed requests, sticky halt.
// Rev 1.0 -- optional statistics counters enabled by BRANCH_ARBITER_STATS_EN.
module branch_arbiter #(
  parameter int NUM_LANES     = vliw_pkg::NUM_LANES,
  parameter int SHADOW_CYCLES = vliw_pkg::SHADOW_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic [NUM_LANES-1:0]    br_valid,
  input  logic [NUM_LANES*32-1:0] br_target,
  input  logic [NUM_LANES-1:0]    halt_req,
  output logic                    branch_taken,
  output logic [31:0]             new_pc,
  output logic [NUM_LANES-1:0]    dont_squash_exec,
  output logic [NUM_LANES-1:0]    dont_squash_dec,
  output logic                    halt_out,
  output logic                    busy_shadow,
  output logic [31:0]             stat_taken,
  output logic [31:0]             stat_dropped
);
  import vliw_pkg::*;

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W = (SHADOW_CYCLES > 0) ? $clog2(SHADOW_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] SHADOW_LOAD = CNT_W'(SHADOW_CYCLES);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             br_any, halt_any;
  logic [IDX_W-1:0] br_idx, halt_idx;
  logic             issue;

  lane_priority_encoder #(.N(NUM_LANES), .IDX_W(IDX_W)) u_br_enc (
    .vec   (br_valid),
    .valid (br_any),
    .idx   (br_idx)
  );

  lane_priority_encoder #(.N(NUM_LANES), .IDX_W(IDX_W)) u_halt_enc (
    .vec   (halt_req),
    .valid (halt_any),
    .idx   (halt_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        // A halt at or before the oldest branch means that branch is never reached.
        issue = br_any && !(halt_any && (halt_idx <= br_idx));
        if (halt_any) begin
          state_d = HALTED;
        end else if (issue && (SHADOW_CYCLES > 0)) begin
          state_d = SHADOW;
          cnt_d   = SHADOW_LOAD;
        end
      end
      SHADOW: begin
        if (!stall) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Input-derived outputs are gated by rst so they read 0 the moment reset asserts.
  always_comb begin
    branch_taken     = rst & issue;
    new_pc           = '0;
    dont_squash_exec = '0;
    if (branch_taken) begin
      new_pc = br_target[int'(br_idx)*32 +: 32];
      for (int i = 0; i < NUM_LANES; i++) begin
        dont_squash_exec[i] = (i < int'(br_idx));
      end
    end
  end

  assign dont_squash_dec = '0;
  assign halt_out        = (state_q == HALTED);
  assign busy_shadow     = (state_q == SHADOW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BRANCH_ARBITER_STATS_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        dropped;

  always_comb begin
    dropped     = br_any && ((state_q != IDLE) || !issue);
    taken_cnt_d = taken_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (issue && (taken_cnt_q != 32'hFFFF_FFFF)) taken_cnt_d = taken_cnt_q + 32'd1;
    if (dropped && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign stat_taken   = taken_cnt_q;
  assign stat_dropped = drop_cnt_q;
`else
  assign stat_taken   = '0;
  assign stat_dropped = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_arbiter.sv
`default_nettype none
// tb_branch_arbiter: randomized + directed scoreboard bench against a behavioural model.
// Rev 1.0
module tb_branch_arbiter;

  localparam int NL = 4;
  localparam int SC = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            stall = 1'b0;
  logic [NL-1:0]   br_valid = '0;
  logic [NL*32-1:0] br_target = '0;
  logic [NL-1:0]   halt_req = '0;
  logic            branch_taken;
  logic [31:0]     new_pc;
  logic [NL-1:0]   dont_squash_exec;
  logic [NL-1:0]   dont_squash_dec;
  logic            halt_out;
  logic            busy_shadow;
  logic [31:0]     stat_taken;
  logic [31:0]     stat_dropped;

  always #5 clk = ~clk;

  branch_arbiter #(.NUM_LANES(NL), .SHADOW_CYCLES(SC)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .br_valid         (br_valid),
    .br_target        (br_target),
    .halt_req         (halt_req),
    .branch_taken     (branch_taken),
    .new_pc           (new_pc),
    .dont_squash_exec (dont_squash_exec),
    .dont_squash_dec  (dont_squash_dec),
    .halt_out         (halt_out),
    .busy_shadow      (busy_shadow),
    .stat_taken       (stat_taken),
    .stat_dropped     (stat_dropped)
  );

  typedef struct packed {
    logic          taken;
    logic [31:0]   pc;
    logic [NL-1:0] dse;
    logic [NL-1:0] dsd;
    logic          halt;
    logic          busy;
    logic [31:0]   st;
    logic [31:0]   sd;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: how many unstalled shadow cycles remain, and whether halted.
  int          shadow_left = 0;
  bit          halted      = 1'b0;
  int unsigned m_taken     = 0;
  int unsigned m_drop      = 0;

  function automatic int lowest(input logic [NL-1:0] v);
    for (int i = 0; i < NL; i++) if (v[i]) return i;
    return NL;
  endfunction

  task automatic drive(input logic r, input logic s, input logic [NL-1:0] bv,
                       input logic [NL-1:0] hv, input logic [NL*32-1:0] tg);
    exp_t e;
    int   lb, lh;
    @(posedge clk);
    #1;
    rst = r; stall = s; br_valid = bv; halt_req = hv; br_target = tg;
    e = '0;
    if (!r) begin
      shadow_left = 0; halted = 1'b0; m_taken = 0; m_drop = 0;
    end else begin
`ifdef BRANCH_ARBITER_STATS_EN
      e.st = m_taken;
      e.sd = m_drop;
`endif
      if (halted) begin
        e.halt = 1'b1;
        if (bv != 0 && m_drop != 32'hFFFF_FFFF) m_drop++;
      end else if (shadow_left > 0) begin
        e.busy = 1'b1;
        if (bv != 0 && m_drop != 32'hFFFF_FFFF) m_drop++;
        if (!s) shadow_left--;
      end else begin
        lb = lowest(bv);
        lh = lowest(hv);
        if (lb < NL && lb < lh) begin
          e.taken = 1'b1;
          e.pc    = tg[lb*32 +: 32];
          for (int i = 0; i < lb; i++) e.dse[i] = 1'b1;
          if (m_taken != 32'hFFFF_FFFF) m_taken++;
        end else if (lb < NL) begin
          if (m_drop != 32'hFFFF_FFFF) m_drop++;
        end
        if (lh < NL) halted = 1'b1;
        else if (e.taken) shadow_left = SC;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("branch_taken", 32'(branch_taken), 32'(e.taken));
        chk("new_pc", new_pc, e.pc);
        chk("dont_squash_exec", 32'(dont_squash_exec), 32'(e.dse));
        chk("dont_squash_dec", 32'(dont_squash_dec), 32'(e.dsd));
        chk("halt_out", 32'(halt_out), 32'(e.halt));
        chk("busy_shadow", 32'(busy_shadow), 32'(e.busy));
        chk("stat_taken", stat_taken, e.st);
        chk("stat_dropped", stat_dropped, e.sd);
      end
    end
  end

  logic [NL*32-1:0] tg_a, tg_b, tg_r;

  initial begin
    tg_a = {32'h0000_00C0, 32'h0000_0080, 32'h0000_0040, 32'h0000_0010};
    tg_b = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};

    repeat (2) drive(1'b0, 1'b0, 4'b1111, 4'b0000, tg_a);

    // Oldest of two branches wins, then two shadow cycles.
    drive(1'b1, 1'b0, 4'b0110, 4'b0000, tg_a);
    drive(1'b1, 1'b0, 4'b0110, 4'b0000, tg_a);
    drive(1'b1, 1'b0, 4'b0110, 4'b0000, tg_a);
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, tg_a);

    // Stall freezes the shadow counter.
    drive(1'b1, 1'b0, 4'b0001, 4'b0000, tg_b);
    repeat (3) drive(1'b1, 1'b1, 4'b0001, 4'b0000, tg_b);
    repeat (3) drive(1'b1, 1'b0, 4'b0001, 4'b0000, tg_b);
    repeat (2) drive(1'b1, 1'b0, 4'b0000, 4'b0000, tg_b);

    // Younger halt lets the older branch through, then halts.
    drive(1'b1, 1'b0, 4'b0001, 4'b0100, tg_b);
    repeat (3) drive(1'b1, 1'b0, 4'b1111, 4'b0000, tg_b);

    // Older halt suppresses the branch.
    drive(1'b0, 1'b0, 4'b0000, 4'b0000, tg_b);
    drive(1'b1, 1'b0, 4'b0010, 4'b0001, tg_b);
    drive(1'b1, 1'b0, 4'b0010, 4'b0000, tg_b);

    // Equal-index halt and branch also suppresses.
    drive(1'b0, 1'b0, 4'b0000, 4'b0000, tg_b);
    drive(1'b1, 1'b0, 4'b0100, 4'b0100, tg_b);
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, tg_b);

    // Reset during shadow, then the youngest lane issues right after release.
    drive(1'b0, 1'b0, 4'b0000, 4'b0000, tg_a);
    drive(1'b1, 1'b0, 4'b0001, 4'b0000, tg_a);
    drive(1'b1, 1'b0, 4'b1111, 4'b0000, tg_a);
    repeat (2) drive(1'b0, 1'b0, 4'b1111, 4'b1111, tg_a);
    drive(1'b1, 1'b0, 4'b1000, 4'b0000, tg_a);
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, tg_a);

    for (int n = 0; n < 1500; n++) begin
      tg_r = {$urandom, $urandom, $urandom, $urandom};
      drive(($urandom_range(0, 39) != 0),
            ($urandom_range(0, 2) == 0),
            NL'($urandom),
            ($urandom_range(0, 11) == 0) ? NL'($urandom) : '0,
            tg_r);
    end

    drive(1'b1, 1'b0, 4'b0000, 4'b0000, tg_a);
    @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_arbiter.md
BRANCH_ARBITER -- requirements
Module: branch_arbiter

Interface
REQ-001 SHALL provide parameter NUM_LANES, default 4, meaning issue lanes per bundle; lane 0 is oldest in program order.
REQ-002 SHALL provide parameter SHADOW_CYCLES, default 2, meaning cycles after a taken branch during which requests come from squashed instructions.
REQ-003 SHALL have ports, one per line, as follows:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-low.
- stall  input  1  pipeline freeze.
- br_valid  input  NUM_LANES  per-lane branch-taken request from the execute stage.
- br_target  input  NUM_LANES x 32  per-lane branch target address.
- halt_req  input  NUM_LANES  per-lane halt instruction at execute.
- branch_taken  output  1  drives the PC branch_taken input.
- new_pc  output  32  winning target; 0 when branch_taken is 0.
- dont_squash_exec  output  NUM_LANES  execute-stage lanes older than the winner.
- dont_squash_dec  output  NUM_LANES  always 0; reserved.
- halt_out  output  1  sticky halt to the PC.
- busy_shadow  output  1  high in the SHADOW state.
- stat_taken  output  32  taken-branch count.
- stat_dropped  output  32  dropped-request count.

Function
REQ-004 SHALL have states IDLE, SHADOW and HALTED, plus a shadow counter of width clog2(SHADOW_CYCLES+1).
REQ-005 In IDLE, the winner SHALL be the lowest-index lane with br_valid=1; branch_taken, new_pc and dont_squash_exec SHALL be combinational in that same cycle (0-cycle latency).
REQ-006 dont_squash_exec SHALL have bit i set iff i < winner index; it SHALL be all zeros when branch_taken=0.
REQ-007 Halt SHALL gate branches: if the lowest halt_req lane index is <= the lowest br_valid lane index, branch_taken SHALL be 0; otherwise the branch SHALL issue.
REQ-008 IDLE SHALL go to SHADOW with counter=SHADOW_CYCLES when a branch issues and stall is ignored; the branch takes priority over stall.
REQ-009 In SHADOW, branch_taken SHALL be 0 and all br_valid SHALL be ignored; the counter SHALL decrement only when stall=0; counter reaching 0 SHALL return the state to IDLE on that same edge.
REQ-010 Any halt_req bit in IDLE SHALL cause a transition to HALTED on the next edge, whether or not a branch also issued; halt_req in SHADOW SHALL be ignored.
REQ-011 HALTED SHALL be terminal until reset; halt_out=1 and branch_taken=0 while HALTED.
REQ-012 Arithmetic: counters SHALL be unsigned; stat counters SHALL saturate at 32'hFFFFFFFF and SHALL NOT wrap.

Reset
REQ-013 rst low SHALL immediately force: state IDLE, counter 0, stat counters 0, and all outputs 0 regardless of inputs.
REQ-014 Reset asserted mid-SHADOW or in HALTED SHALL return the block to IDLE; the first edge after rst deasserts SHALL evaluate requests normally.

Configuration
REQ-015 Macro BRANCH_ARBITER_STATS_EN, when defined, SHALL enable the counters: stat_taken increments per issued branch, and stat_dropped increments once per cycle when any br_valid bit is ignored (in SHADOW, or suppressed by halt).
REQ-016 Without BRANCH_ARBITER_STATS_EN, stat_taken and stat_dropped SHALL be tied to 0 and no counter flops SHALL be synthesised; the ports remain present.

Structure
REQ-017 Package vliw_pkg SHALL hold NUM_LANES, SHADOW_CYCLES and the enum arb_state_t {IDLE, SHADOW, HALTED}.
REQ-018 A sub-module lane_priority_encoder SHALL be used to turn a NUM_LANES vector into a valid flag and a lowest-set index; it SHALL be instantiated twice, once for br_valid and once for halt_req.

Verification
REQ-019 br_valid=4'b0110, br_target[1]=32'h40, br_target[2]=32'h80 in IDLE -> same cycle: branch_taken=1, new_pc=32'h40, dont_squash_exec=4'b0001; next 2 cycles: branch_taken=0.
REQ-020 Branch in IDLE, then stall=1 for 3 cycles, then br_valid=4'b0001 held -> branch ignored until 2 unstalled cycles elapse, then issued.
REQ-021 halt_req=4'b0100 with br_valid=4'b0001 -> branch issued to its target; next edge HALTED, halt_out=1; later br_valid=4'b1111 -> branch_taken=0.
REQ-022 halt_req=4'b0001 with br_valid=4'b0010 -> branch_taken=0, and halt_out=1 on the next edge.
REQ-023 rst driven low during SHADOW, then released -> outputs 0 during reset; br_valid=4'b1000 on the first cycle after release -> issued with dont_squash_exec=4'b0111.
REQ-024 With BRANCH_ARBITER_STATS_EN, 3 issued branches and 2 shadowed requests -> stat_taken=3, stat_dropped=2; without the macro, both read 0.
